rv_iret_trace_buf: RTL and testbench

RV_IRET_TRACE_BUF -- requirements
Module: rv_iret_trace_buf

---
 rtl/rv_iret_trace_buf.sv | 127 ++++++++++++
 tb/tb_rv_iret_trace_buf.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_iret_trace_buf.sv
// Retired-instruction trace buffer: a circular FIFO of retirement records with
// sequence numbering, sticky overflow tracking and a saturating drop counter.
module rv_iret_trace_buf #(
    parameter int XLEN  = 32,
    parameter int FLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iret,
    input  logic [XLEN-1:0]          iret_addr,
    input  logic [31:0]              iret_insn,
    input  logic [XLEN-1:0]          iret_ires,
    input  logic [FLEN-1:0]          iret_fres,
    input  logic                     flush,
    input  logic                     ovf_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_addr,
    output logic [31:0]              out_insn,
    output logic [XLEN-1:0]          out_ires,
    output logic [FLEN-1:0]          out_fres,
    output logic [63:0]              out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    output logic [63:0]              instret
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [31:0]     insn;
        logic [XLEN-1:0] ires;
        logic [FLEN-1:0] fres;
        logic [63:0]     seq;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic [63:0]     instret_q, instret_d;

    logic pop, push, drop, full;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        full = (count_q == FULL);
        pop  = (count_q != '0) && out_ready && !flush;
        push = iret && !flush && (!full || pop);
        drop = iret && !flush && full && !pop;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are PW bits wide and DEPTH is a power of two, so they wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        instret_d = instret_q + {63'd0, iret};

        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 1'b1;

        // A drop in the same cycle as ovf_clr keeps the flag set.
        if (drop)         overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;
    end

    // NOTE: control state uses non-blocking assignments and async reset; storage below does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            instret_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            instret_q  <= instret_d;
        end
    end

    // NOTE: storage is deliberately not reset; entries are only observable while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: iret_addr, insn: iret_insn, ires: iret_ires,
                                 fres: iret_fres, seq: instret_q};
        end
    end

    assign out_valid = (count_q != '0);
    assign out_addr  = mem_q[rd_ptr_q].addr;
    assign out_insn  = mem_q[rd_ptr_q].insn;
    assign out_ires  = mem_q[rd_ptr_q].ires;
    assign out_fres  = mem_q[rd_ptr_q].fres;
    assign out_seq   = mem_q[rd_ptr_q].seq;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_rv_iret_trace_buf.sv
// Scoreboard bench for rv_iret_trace_buf: the stimulus side predicts accepted
// records into a queue, a negedge monitor pops and compares what the DUT presents.
module tb_rv_iret_trace_buf;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          iret = 1'b0;
    logic [31:0]   iret_addr = '0, iret_insn = '0, iret_ires = '0, iret_fres = '0;
    logic          flush = 1'b0, ovf_clr = 1'b0, out_ready = 1'b0;
    logic          out_valid;
    logic [31:0]   out_addr, out_insn, out_ires, out_fres;
    logic [63:0]   out_seq, instret;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   drop_cnt;

    rv_iret_trace_buf #(.XLEN(32), .FLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .iret(iret), .iret_addr(iret_addr),
        .iret_insn(iret_insn), .iret_ires(iret_ires), .iret_fres(iret_fres),
        .flush(flush), .ovf_clr(ovf_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_insn(out_insn), .out_ires(out_ires), .out_fres(out_fres),
        .out_seq(out_seq), .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr, insn, ires, fres;
        logic [63:0] seq;
        int          vis;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    // Model state after the upcoming edge, and the state the DUT should show this cycle.
    logic [63:0] m_instret = '0, cur_instret = '0;
    logic [15:0] m_drop = '0, cur_drop = '0;
    logic        m_ovf = 1'b0, cur_ovf = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compare the visible head and status, then retire popped/flushed entries.
    always @(negedge clk) begin
        int vis_n;
        if (rst_n) begin
            vis_n = 0;
            foreach (exp_q[i]) if (exp_q[i].vis <= cyc) vis_n++;
            check("count", count, vis_n);
            check("out_valid", out_valid, vis_n != 0);
            check("instret", instret, cur_instret);
            check("drop_cnt", drop_cnt, cur_drop);
            check("overflow", overflow, cur_ovf);
            if (vis_n != 0) begin
                check("out_addr", out_addr, exp_q[0].addr);
                check("out_insn", out_insn, exp_q[0].insn);
                check("out_ires", out_ires, exp_q[0].ires);
                check("out_fres", out_fres, exp_q[0].fres);
                check("out_seq", out_seq, exp_q[0].seq);
                if (out_ready && !flush) void'(exp_q.pop_front());
            end
            if (flush) exp_q.delete();
        end
    end

    task automatic drive(input logic ir, input logic [31:0] a, input logic rdy,
                         input logic fl, input logic oc);
        int  occ;
        logic pop, push, drop;
        @(posedge clk); #1;
        iret = ir; iret_addr = a; iret_insn = $urandom;
        iret_ires = $urandom; iret_fres = $urandom;
        out_ready = rdy; flush = fl; ovf_clr = oc;
        occ  = exp_q.size();
        pop  = (occ != 0) && rdy && !fl;
        push = ir && !fl && (occ < DEPTH || pop);
        drop = ir && !fl && occ == DEPTH && !pop;
        cur_instret = m_instret; cur_drop = m_drop; cur_ovf = m_ovf;
        if (push) exp_q.push_back('{addr: a, insn: iret_insn, ires: iret_ires,
                                    fres: iret_fres, seq: m_instret, vis: cyc + 1});
        if (ir) m_instret++;
        if (drop && m_drop != 16'hFFFF) m_drop++;
        m_ovf = drop ? 1'b1 : (oc ? 1'b0 : m_ovf);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; iret = 1'b0; flush = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        exp_q.delete();
        m_instret = '0; m_drop = '0; m_ovf = 1'b0;
        cur_instret = '0; cur_drop = '0; cur_ovf = 1'b0;
        #1;
        check("rst count", count, 0);
        check("rst out_valid", out_valid, 0);
        check("rst overflow", overflow, 0);
        check("rst drop_cnt", drop_cnt, 0);
        check("rst instret", instret, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] ir_before;
        logic [15:0] dr_before;

        do_reset();

        // Three retirements into a stalled consumer.
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
        idle();
        check("d3 count", count, 3);
        check("d3 out_addr", out_addr, 32'h100);
        check("d3 out_seq", out_seq, 0);
        check("d3 instret", instret, 3);

        // Three more: one fills the buffer, two are dropped.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h10C + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        idle();
        check("d6 count", count, 4);
        check("d6 drop_cnt", drop_cnt, 2);
        check("d6 overflow", overflow, 1);
        check("d6 instret", instret, 6);
        check("d6 out_seq", out_seq, 0);

        // Full buffer: pop and push together is accepted, not dropped.
        drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        idle();
        check("fullpp count", count, 4);
        check("fullpp drop_cnt", drop_cnt, 2);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle();
        check("drained count", count, 0);

        // Drop together with ovf_clr keeps overflow; ovf_clr alone clears it.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h310, 1'b0, 1'b0, 1'b1);
        idle();
        check("ovf set wins", overflow, 1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle();
        check("ovf cleared", overflow, 0);

        // Flush with count=2, plus iret and out_ready in the same cycle.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
        ir_before = m_instret;
        dr_before = m_drop;
        drive(1'b1, 32'h408, 1'b1, 1'b1, 1'b0);
        idle();
        check("flush count", count, 0);
        check("flush out_valid", out_valid, 0);
        check("flush instret", instret, ir_before + 64'd1);
        check("flush drop_cnt", drop_cnt, dr_before);

        // Reset mid-stream with three entries buffered.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        do_reset();
        drive(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
        idle();
        check("post-rst out_valid", out_valid, 1);
        check("post-rst out_seq", out_seq, 0);
        check("post-rst out_addr", out_addr, 32'h600);

        // Randomised traffic, with rare resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(99) < 60, $urandom, $urandom_range(1),
                      $urandom_range(99) < 3, $urandom_range(99) < 5);
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle();
        check("final count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
